writeback_queue: RTL and testbench

Write-side arbiter and buffer in front of the 32x32 register file's single write port. It merges single-cycle pipeline results with results from a long-latency unit (multiplier/divider, multi-cycle loads) into one registered write stream. It enforces program order by cancelling stale buffered writes and forwards not-yet-committed values to the three read ports.

---
 rtl/writeback_queue.sv | 155 +++++++++++++++
 tb/tb_writeback_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: merges pipeline and long-latency results into the single
// register-file write port, keeps program order by killing stale buffered
// writes, and forwards uncommitted values to three read ports.
module writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_reg,
  input  logic [DATA_W-1:0]             pipe_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_reg,
  input  logic [DATA_W-1:0]             lu_data,
  output logic                          EnableWrite,
  output logic [4:0]                    write_reg,
  output logic [DATA_W-1:0]             write_data,
  input  logic [4:0]                    read_reg1,
  input  logic [4:0]                    read_reg2,
  input  logic [4:0]                    read_reg3,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic                          fwd_hit3,
  output logic [DATA_W-1:0]             fwd_data1,
  output logic [DATA_W-1:0]             fwd_data2,
  output logic [DATA_W-1:0]             fwd_data3,
  output logic [$clog2(DEPTH):0]        pending
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned NRD = 3;

  // Buffer storage; a live bit is only ever set on an occupied slot
  logic [4:0]        r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  // Registered write port
  logic              r_we;
  logic [4:0]        r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic              w_pipe_act;
  logic              w_lu_xfer;
  logic              w_push;
  logic              w_pop;
  logic [4:0]        w_rd    [NRD];
  logic [NRD-1:0]    w_hit;
  logic [DATA_W-1:0] w_fdata [NRD];

  assign w_pipe_act = pipe_we && (pipe_reg != 5'd0);
  assign lu_ready   = (r_count < CW'(DEPTH)) && !rst;
  assign w_lu_xfer  = lu_valid && lu_ready;
  // r0 targets and results overtaken by a same-cycle pipe write are dropped
  assign w_push     = w_lu_xfer && (lu_reg != 5'd0) &&
                      !(w_pipe_act && (pipe_reg == lu_reg));
  assign w_pop      = !w_pipe_act && (r_count != CW'(0));

  // Buffer bookkeeping, kill tracking and write-port issue
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_reg[i]  <= 5'd0;
        r_data[i] <= '0;
      end
      r_live  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_wreg  <= 5'd0;
      r_wdata <= '0;
    end else begin
      if (w_pipe_act) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (r_reg[i] == pipe_reg) r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + AW'(1);
      end
      if (w_push) begin
        r_reg[r_tail]  <= lu_reg;
        r_data[r_tail] <= lu_data;
        r_live[r_tail] <= 1'b1;
        r_tail         <= r_tail + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_pipe_act) begin
        r_we    <= 1'b1;
        r_wreg  <= pipe_reg;
        r_wdata <= pipe_data;
      end else if (w_pop) begin
        r_we <= r_live[r_head];
        if (r_live[r_head]) begin
          r_wreg  <= r_reg[r_head];
          r_wdata <= r_data[r_head];
        end
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign w_rd[0] = read_reg1;
  assign w_rd[1] = read_reg2;
  assign w_rd[2] = read_reg3;

  // Forwarding: scan buffer oldest to youngest, then let newer sources override
  always_comb begin
    logic [AW-1:0] idx;
    idx = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      w_hit[k]   = 1'b0;
      w_fdata[k] = '0;
      if (w_rd[k] != 5'd0) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          idx = r_head + AW'(i);
          if (r_live[idx] && (r_reg[idx] == w_rd[k])) begin
            w_hit[k]   = 1'b1;
            w_fdata[k] = r_data[idx];
          end
        end
        if (r_we && (r_wreg == w_rd[k])) begin
          w_hit[k]   = 1'b1;
          w_fdata[k] = r_wdata;
        end
        if (w_pipe_act && (pipe_reg == w_rd[k])) begin
          w_hit[k]   = 1'b1;
          w_fdata[k] = pipe_data;
        end
      end
    end
  end

  assign EnableWrite = r_we;
  assign write_reg   = r_wreg;
  assign write_data  = r_wdata;
  assign pending     = r_count;
  assign fwd_hit1    = w_hit[0];
  assign fwd_hit2    = w_hit[1];
  assign fwd_hit3    = w_hit[2];
  assign fwd_data1   = w_fdata[0];
  assign fwd_data2   = w_fdata[1];
  assign fwd_data3   = w_fdata[2];

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: scripted scenarios plus a
// scoreboard monitor that checks every issued write against expected order.
module tb_writeback_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we;
  logic [4:0]        pipe_reg;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [4:0]        lu_reg;
  logic [DATA_W-1:0] lu_data;
  logic              EnableWrite;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [4:0]        read_reg1, read_reg2, read_reg3;
  logic              fwd_hit1, fwd_hit2, fwd_hit3;
  logic [DATA_W-1:0] fwd_data1, fwd_data2, fwd_data3;
  logic [2:0]        pending;

  int  pass_cnt  = 0;
  int  total_cnt = 0;
  wr_t expq[$];

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_reg3(read_reg3),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_hit3(fwd_hit3),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_data3(fwd_data3),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issued write must match the oldest expected write
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (EnableWrite === 1'b1) begin
      total_cnt++;
      if (expq.size() == 0) begin
        $display("FAIL sb_unexpected: got r%0d=%0d, required no write", write_reg, write_data);
      end else begin
        e = expq.pop_front();
        if (write_reg !== e.r || write_data !== e.d)
          $display("FAIL sb_order: got r%0d=%0d, required r%0d=%0d", write_reg, write_data, e.r, e.d);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we  = 1'b0;
    lu_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pipe_we = 1'b0; pipe_reg = 5'd0; pipe_data = '0;
    lu_valid = 1'b1; lu_reg = 5'd3; lu_data = 32'd77;
    read_reg1 = 5'd0; read_reg2 = 5'd0; read_reg3 = 5'd0;
    tick(); tick();
    total_cnt++; if (EnableWrite !== 1'b0) $display("FAIL rst_we: got %b required 0", EnableWrite); else pass_cnt++;
    total_cnt++; if (write_reg !== 5'd0) $display("FAIL rst_wreg: got %0d required 0", write_reg); else pass_cnt++;
    total_cnt++; if (write_data !== '0) $display("FAIL rst_wdata: got %0d required 0", write_data); else pass_cnt++;
    total_cnt++; if (lu_ready !== 1'b0) $display("FAIL rst_lu_ready: got %b required 0", lu_ready); else pass_cnt++;
    total_cnt++; if (pending !== 3'd0) $display("FAIL rst_pending: got %0d required 0", pending); else pass_cnt++;
    rst = 1'b0; lu_valid = 1'b0;
    #1;
    total_cnt++; if (lu_ready !== 1'b1) $display("FAIL rel_lu_ready: got %b required 1", lu_ready); else pass_cnt++;
  endtask

  task automatic test_pipe();
    pipe_we = 1'b1; pipe_reg = 5'd9; pipe_data = 32'd6;
    expq.push_back('{r: 5'd9, d: 32'd6});
    tick();
    total_cnt++; if (EnableWrite !== 1'b1) $display("FAIL pipe_we: got %b required 1", EnableWrite); else pass_cnt++;
    total_cnt++; if (write_reg !== 5'd9) $display("FAIL pipe_wreg: got %0d required 9", write_reg); else pass_cnt++;
    total_cnt++; if (write_data !== 32'd6) $display("FAIL pipe_wdata: got %0d required 6", write_data); else pass_cnt++;
    pipe_reg = 5'd0; pipe_data = 32'd123;
    tick();
    total_cnt++; if (EnableWrite !== 1'b0) $display("FAIL pipe_r0_we: got %b required 0", EnableWrite); else pass_cnt++;
    total_cnt++; if (write_reg !== 5'd9) $display("FAIL pipe_hold_wreg: got %0d required 9", write_reg); else pass_cnt++;
    idle();
  endtask

  task automatic test_backpressure();
    logic [4:0]        lr [4];
    logic [DATA_W-1:0] ld [4];
    lr[0] = 5'd19; lr[1] = 5'd20; lr[2] = 5'd21; lr[3] = 5'd16;
    ld[0] = 32'd2; ld[1] = 32'd15; ld[2] = 32'd40; ld[3] = 32'd232;
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_reg = 5'(i + 1); pipe_data = 32'(100 + i);
      lu_valid = 1'b1; lu_reg = lr[i]; lu_data = ld[i];
      expq.push_back('{r: 5'(i + 1), d: 32'(100 + i)});
      #1;
      total_cnt++; if (lu_ready !== 1'b1) $display("FAIL bp_ready_%0d: got %b required 1", i, lu_ready); else pass_cnt++;
      tick();
    end
    total_cnt++; if (pending !== 3'd4) $display("FAIL bp_full: got %0d required 4", pending); else pass_cnt++;
    total_cnt++; if (lu_ready !== 1'b0) $display("FAIL bp_ready_full: got %b required 0", lu_ready); else pass_cnt++;
    pipe_reg = 5'd5; pipe_data = 32'd105; lu_reg = 5'd22; lu_data = 32'd99;
    expq.push_back('{r: 5'd5, d: 32'd105});
    tick();
    total_cnt++; if (pending !== 3'd4) $display("FAIL bp_stall: got %0d required 4", pending); else pass_cnt++;
    idle();
    for (int i = 0; i < 4; i++) expq.push_back('{r: lr[i], d: ld[i]});
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (write_reg !== lr[i] || EnableWrite !== 1'b1)
        $display("FAIL bp_drain_%0d: got we=%b r%0d required we=1 r%0d", i, EnableWrite, write_reg, lr[i]); else pass_cnt++;
      total_cnt++; if (pending !== 3'(3 - i)) $display("FAIL bp_pending_%0d: got %0d required %0d", i, pending, 3 - i); else pass_cnt++;
    end
    tick();
    total_cnt++; if (EnableWrite !== 1'b0) $display("FAIL bp_idle: got %b required 0", EnableWrite); else pass_cnt++;
  endtask

  task automatic test_kill();
    lu_valid = 1'b1; lu_reg = 5'd10; lu_data = 32'd60;
    tick();
    lu_valid = 1'b0; pipe_we = 1'b1; pipe_reg = 5'd10; pipe_data = 32'd99;
    expq.push_back('{r: 5'd10, d: 32'd99});
    tick();
    total_cnt++; if (write_data !== 32'd99) $display("FAIL kill_data: got %0d required 99", write_data); else pass_cnt++;
    total_cnt++; if (pending !== 3'd1) $display("FAIL kill_pending: got %0d required 1", pending); else pass_cnt++;
    pipe_we = 1'b0;
    tick();
    total_cnt++; if (EnableWrite !== 1'b0) $display("FAIL kill_drain_we: got %b required 0", EnableWrite); else pass_cnt++;
    total_cnt++; if (pending !== 3'd0) $display("FAIL kill_drain_pending: got %0d required 0", pending); else pass_cnt++;
    // Same-cycle lu result to the pipe's target, and an r0 result: neither enqueued
    pipe_we = 1'b1; pipe_reg = 5'd12; pipe_data = 32'd5;
    lu_valid = 1'b1; lu_reg = 5'd12; lu_data = 32'd6;
    expq.push_back('{r: 5'd12, d: 32'd5});
    tick();
    total_cnt++; if (pending !== 3'd0) $display("FAIL kill_same_cycle: got %0d required 0", pending); else pass_cnt++;
    pipe_we = 1'b0; lu_reg = 5'd0; lu_data = 32'd8;
    tick();
    total_cnt++; if (pending !== 3'd0) $display("FAIL lu_r0: got %0d required 0", pending); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_forwarding();
    pipe_we = 1'b1; pipe_reg = 5'd2; pipe_data = 32'd1;
    lu_valid = 1'b1; lu_reg = 5'd21; lu_data = 32'd40;
    expq.push_back('{r: 5'd2, d: 32'd1});
    tick();
    pipe_reg = 5'd3; pipe_data = 32'd2; lu_data = 32'd41;
    expq.push_back('{r: 5'd3, d: 32'd2});
    tick();
    lu_valid = 1'b0; pipe_reg = 5'd4; pipe_data = 32'd3;
    read_reg1 = 5'd3; read_reg2 = 5'd21; read_reg3 = 5'd0;
    #1;
    total_cnt++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'd41)
      $display("FAIL fwd_youngest: got hit=%b data=%0d required hit=1 data=41", fwd_hit2, fwd_data2); else pass_cnt++;
    total_cnt++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd2)
      $display("FAIL fwd_outreg: got hit=%b data=%0d required hit=1 data=2", fwd_hit1, fwd_data1); else pass_cnt++;
    total_cnt++; if (fwd_hit3 !== 1'b0 || fwd_data3 !== '0)
      $display("FAIL fwd_r0: got hit=%b data=%0d required hit=0 data=0", fwd_hit3, fwd_data3); else pass_cnt++;
    pipe_reg = 5'd21; pipe_data = 32'd7; read_reg1 = 5'd30;
    expq.push_back('{r: 5'd21, d: 32'd7});
    #1;
    total_cnt++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'd7)
      $display("FAIL fwd_pipe: got hit=%b data=%0d required hit=1 data=7", fwd_hit2, fwd_data2); else pass_cnt++;
    total_cnt++; if (fwd_hit1 !== 1'b0) $display("FAIL fwd_miss: got %b required 0", fwd_hit1); else pass_cnt++;
    tick();
    pipe_we = 1'b0;
    #1;
    total_cnt++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'd7)
      $display("FAIL fwd_after_kill: got hit=%b data=%0d required hit=1 data=7", fwd_hit2, fwd_data2); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (pending !== 3'd0 || EnableWrite !== 1'b0)
      $display("FAIL fwd_drain: got pending=%0d we=%b required pending=0 we=0", pending, EnableWrite); else pass_cnt++;
    total_cnt++; if (fwd_hit2 !== 1'b0) $display("FAIL fwd_empty: got %b required 0", fwd_hit2); else pass_cnt++;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_reg = 5'd5; pipe_data = 32'(i);
      lu_valid = 1'b1; lu_reg = 5'(6 + i); lu_data = 32'(50 + i);
      expq.push_back('{r: 5'd5, d: 32'(i)});
      tick();
    end
    total_cnt++; if (pending !== 3'd3) $display("FAIL mr_fill: got %0d required 3", pending); else pass_cnt++;
    idle(); rst = 1'b1;
    tick();
    total_cnt++; if (pending !== 3'd0 || EnableWrite !== 1'b0)
      $display("FAIL mr_reset: got pending=%0d we=%b required pending=0 we=0", pending, EnableWrite); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if (EnableWrite !== 1'b0) $display("FAIL mr_no_write_%0d: got %b required 0", i, EnableWrite); else pass_cnt++;
    end
    total_cnt++; if (expq.size() != 0) $display("FAIL sb_leftover: got %0d pending expectations required 0", expq.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_backpressure();
    test_kill();
    test_forwarding();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
